// File: rtl/gcd_scheduler.sv
// Round-robin front end sharing one external GCD engine among NumReq requesters.
// Optional WAIT timeout when GCD_SCHED_TIMEOUT_EN is defined.
module gcd_scheduler #(
    parameter int BusSize    = 8,
    parameter int NumReq     = 4,
    parameter int LoadCyc    = 2,
    parameter int TimeoutCyc = 1024
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic [NumReq-1:0]         req_in,
    input  logic [NumReq*BusSize-1:0] a_in,
    input  logic [NumReq*BusSize-1:0] b_in,
    output logic [NumReq-1:0]         gnt_out,
    output logic [NumReq-1:0]         rsp_valid_out,
    output logic [BusSize-1:0]        rsp_data_out,
    output logic                      rsp_err_out,
    output logic                      busy_out,
    output logic [BusSize-1:0]        eng_a_out,
    output logic [BusSize-1:0]        eng_b_out,
    output logic                      eng_go_out,
    input  logic                      eng_done_in,
    input  logic [BusSize-1:0]        eng_result_in
);

    // state  | meaning
    // IDLE   | arbitrate among req_in, latch winner operands
    // ISSUE  | engine go held, done masked for LoadCyc cycles
    // WAIT   | engine go held, waiting for done (or timeout)
    // RESP   | one-cycle response pulse to the granted requester

    localparam int IdW    = $clog2(NumReq);
    localparam int CntMax = (LoadCyc > TimeoutCyc) ? LoadCyc : TimeoutCyc;
    localparam int CntW   = $clog2(CntMax + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t               state_q, state_nxt;
    logic [IdW-1:0]       rr_ptr_q, rr_ptr_nxt, win;
    logic [IdW:0]         idx_sum;
    logic [CntW-1:0]      cnt_q, cnt_nxt;
    logic [NumReq-1:0]    gnt_nxt, rsp_valid_nxt;
    logic [BusSize-1:0]   rsp_data_nxt, eng_a_nxt, eng_b_nxt;
    logic                 rsp_err_nxt, busy_nxt, eng_go_nxt;

    // First requesting index after rr_ptr; scanning downward leaves the nearest one.
    always_comb begin
        win     = rr_ptr_q;
        idx_sum = '0;
        for (int i = NumReq; i >= 1; i--) begin
            idx_sum = {1'b0, rr_ptr_q} + (IdW+1)'(i);
            if (idx_sum >= (IdW+1)'(NumReq)) begin
                idx_sum = idx_sum - (IdW+1)'(NumReq);
            end
            if (req_in[idx_sum[IdW-1:0]]) begin
                win = idx_sum[IdW-1:0];
            end
        end
    end

    // rr_ptr doubles as the id of the job in flight: it always equals the last winner.
    always_comb begin
        state_nxt     = state_q;
        rr_ptr_nxt    = rr_ptr_q;
        cnt_nxt       = cnt_q;
        gnt_nxt       = '0;
        rsp_valid_nxt = '0;
        rsp_data_nxt  = rsp_data_out;
        rsp_err_nxt   = rsp_err_out;
        eng_a_nxt     = eng_a_out;
        eng_b_nxt     = eng_b_out;

        case (state_q)
            S_IDLE: begin
                if (|req_in) begin
                    state_nxt  = S_ISSUE;
                    rr_ptr_nxt = win;
                    gnt_nxt    = NumReq'(1) << win;
                    eng_a_nxt  = BusSize'(a_in >> (int'(win) * BusSize));
                    eng_b_nxt  = BusSize'(b_in >> (int'(win) * BusSize));
                    cnt_nxt    = CntW'(LoadCyc - 1);
                end
            end
            S_ISSUE: begin
                if (cnt_q == '0) begin
                    state_nxt = S_WAIT;
`ifdef GCD_SCHED_TIMEOUT_EN
                    cnt_nxt   = CntW'(TimeoutCyc - 1);
`endif
                end else begin
                    cnt_nxt = cnt_q - CntW'(1);
                end
            end
            S_WAIT: begin
                if (eng_done_in) begin
                    state_nxt     = S_RESP;
                    rsp_data_nxt  = eng_result_in;
                    rsp_err_nxt   = 1'b0;
                    rsp_valid_nxt = NumReq'(1) << rr_ptr_q;
                end
`ifdef GCD_SCHED_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    state_nxt     = S_RESP;
                    rsp_data_nxt  = '0;
                    rsp_err_nxt   = 1'b1;
                    rsp_valid_nxt = NumReq'(1) << rr_ptr_q;
                end else begin
                    cnt_nxt = cnt_q - CntW'(1);
                end
`endif
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        eng_go_nxt = (state_nxt == S_ISSUE) || (state_nxt == S_WAIT);
        busy_nxt   = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= IdW'(NumReq - 1);
            cnt_q         <= '0;
            gnt_out       <= '0;
            rsp_valid_out <= '0;
            rsp_data_out  <= '0;
            rsp_err_out   <= 1'b0;
            busy_out      <= 1'b0;
            eng_a_out     <= '0;
            eng_b_out     <= '0;
            eng_go_out    <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            rr_ptr_q      <= rr_ptr_nxt;
            cnt_q         <= cnt_nxt;
            gnt_out       <= gnt_nxt;
            rsp_valid_out <= rsp_valid_nxt;
            rsp_data_out  <= rsp_data_nxt;
            rsp_err_out   <= rsp_err_nxt;
            busy_out      <= busy_nxt;
            eng_a_out     <= eng_a_nxt;
            eng_b_out     <= eng_b_nxt;
            eng_go_out    <= eng_go_nxt;
        end
    end

endmodule

// File: tb/tb_gcd_scheduler.sv
// Directed bench for gcd_scheduler with a behavioural GCD engine and grant/response scoreboards.
// The timeout step is compiled only when GCD_SCHED_TIMEOUT_EN is defined.
module tb_gcd_scheduler;

    localparam int BW = 8;
    localparam int NR = 4;
    localparam int LC = 2;
    localparam int TC = 16;

    logic                 clk_in = 1'b0;
    logic                 rst_n_in;
    logic [NR-1:0]        req_in;
    logic [NR*BW-1:0]     a_in;
    logic [NR*BW-1:0]     b_in;
    logic [NR-1:0]        gnt_out;
    logic [NR-1:0]        rsp_valid_out;
    logic [BW-1:0]        rsp_data_out;
    logic                 rsp_err_out;
    logic                 busy_out;
    logic [BW-1:0]        eng_a_out;
    logic [BW-1:0]        eng_b_out;
    logic                 eng_go_out;
    logic                 eng_done_in;
    logic [BW-1:0]        eng_result_in;

    gcd_scheduler #(
        .BusSize(BW), .NumReq(NR), .LoadCyc(LC), .TimeoutCyc(TC)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .req_in(req_in), .a_in(a_in), .b_in(b_in),
        .gnt_out(gnt_out), .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out),
        .rsp_err_out(rsp_err_out), .busy_out(busy_out), .eng_a_out(eng_a_out),
        .eng_b_out(eng_b_out), .eng_go_out(eng_go_out), .eng_done_in(eng_done_in),
        .eng_result_in(eng_result_in)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int            id;
        logic [BW-1:0] data;
        logic          err;
    } rsp_t;

    rsp_t rq[$];
    int   gq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   eng_lat = 3;
    bit   stale_mode = 1'b0;
    bit   eng_off = 1'b0;
    bit   mon_en = 1'b0;

    function automatic logic [BW-1:0] gcd(logic [BW-1:0] a, logic [BW-1:0] b);
        logic [BW-1:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Engine: clears done when a job starts (later in stale mode), then reports after eng_lat cycles.
    initial begin
        int go_cnt;
        int clr_k;
        go_cnt        = 0;
        eng_done_in   = 1'b0;
        eng_result_in = '0;
        forever begin
            @(negedge clk_in);
            if (eng_go_out !== 1'b1) begin
                go_cnt = 0;
            end else begin
                go_cnt++;
                clr_k = stale_mode ? (LC + 1) : 1;
                if (go_cnt == clr_k) eng_done_in = 1'b0;
                if (go_cnt == clr_k + eng_lat && !eng_off) begin
                    eng_result_in = gcd(eng_a_out, eng_b_out);
                    eng_done_in   = 1'b1;
                end
            end
        end
    end

    // Scoreboard monitor for grant and response pulses.
    initial begin
        rsp_t r;
        int   e;
        forever begin
            @(negedge clk_in);
            if (mon_en && gnt_out !== '0) begin
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", 32'(gnt_out), 0);
                end else begin
                    e = gq.pop_front();
                    chk("gnt_order", 32'(gnt_out), 32'(1 << e));
                end
            end
            if (mon_en && rsp_valid_out !== '0) begin
                if (rq.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid_out), 0);
                end else begin
                    r = rq.pop_front();
                    chk("rsp_valid", 32'(rsp_valid_out), 32'(1 << r.id));
                    chk("rsp_data", 32'(rsp_data_out), 32'(r.data));
                    chk("rsp_err", 32'(rsp_err_out), 32'(r.err));
                end
            end
        end
    end

    task automatic issue(input int id, input logic [BW-1:0] a, input logic [BW-1:0] b,
                         input bit push_rsp, input logic [BW-1:0] exp, input logic err,
                         output int lat);
        rsp_t r;
        a_in[id*BW +: BW] = a;
        b_in[id*BW +: BW] = b;
        req_in[id]        = 1'b1;
        gq.push_back(id);
        if (push_rsp) begin
            r.id   = id;
            r.data = exp;
            r.err  = err;
            rq.push_back(r);
        end
        lat = 0;
        do begin
            @(negedge clk_in);
            lat++;
        end while (gnt_out[id] !== 1'b1 && lat < 100);
        if (lat >= 100) chk("gnt_timeout", 32'(lat), 0);
        req_in[id] = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (rsp_valid_out === '0 && n < 200);
        if (n >= 200) chk("rsp_timeout", 32'(n), 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rq.size() != 0 || busy_out !== 1'b0) && n < 300) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 300) chk("drain_timeout", 32'(rq.size()), 0);
    endtask

    initial begin
        int lat;
        int n;
        int grants;
        bit first0;
        int req_id;
        logic [BW-1:0] ea[4];
        logic [BW-1:0] eb[4];
        logic [BW-1:0] ex[4];

        rst_n_in = 1'b0;
        req_in   = '0;
        a_in     = '0;
        b_in     = '0;
        repeat (3) @(negedge clk_in);
        chk("rst_busy", 32'(busy_out), 0);
        chk("rst_gnt", 32'(gnt_out), 0);
        chk("rst_rsp_valid", 32'(rsp_valid_out), 0);
        chk("rst_rsp_data", 32'(rsp_data_out), 0);
        chk("rst_rsp_err", 32'(rsp_err_out), 0);
        chk("rst_eng_go", 32'(eng_go_out), 0);
        chk("rst_eng_a", 32'(eng_a_out), 0);
        chk("rst_eng_b", 32'(eng_b_out), 0);
        rst_n_in = 1'b1;
        mon_en   = 1'b1;
        @(negedge clk_in);

        // Fairness: all four requesting, requester 0 re-requests once.
        a_in   = {8'd17, 8'd35, 8'd9, 8'd12};
        b_in   = {8'd5, 8'd14, 8'd6, 8'd8};
        req_in = 4'b1111;
        gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(3); gq.push_back(0);
        rq.push_back('{0, 8'd4, 1'b0});
        rq.push_back('{1, 8'd3, 1'b0});
        rq.push_back('{2, 8'd7, 1'b0});
        rq.push_back('{3, 8'd1, 1'b0});
        rq.push_back('{0, 8'd4, 1'b0});
        grants = 0;
        first0 = 1'b0;
        n      = 0;
        while (grants < 5 && n < 500) begin
            @(negedge clk_in);
            n++;
            for (int i = 0; i < NR; i++) begin
                if (gnt_out[i] === 1'b1) begin
                    grants++;
                    if (i == 0 && !first0) first0 = 1'b1;
                    else req_in[i] = 1'b0;
                end
            end
        end
        chk("fair_grants", 32'(grants), 5);
        drain();

        // Single request with latency checks.
        eng_lat = 3;
        issue(0, 8'd48, 8'd18, 1'b1, 8'd6, 1'b0, lat);
        chk("single_gnt_lat", 32'(lat), 1);
        wait_rsp(n);
        chk("single_rsp_lat", 32'(n), 4);
        drain();

        // Edge operands on rotating requesters.
        ea = '{8'd0, 8'd7, 8'd0, 8'd255};
        eb = '{8'd7, 8'd0, 8'd0, 8'd255};
        ex = '{8'd7, 8'd7, 8'd0, 8'd255};
        for (int i = 0; i < 4; i++) begin
            req_id = (i + 1) % NR;
            issue(req_id, ea[i], eb[i], 1'b1, ex[i], 1'b0, lat);
            drain();
        end

        // Stale done (255 left over) must be masked during ISSUE.
        stale_mode = 1'b1;
        eng_lat    = 2;
        issue(1, 8'd40, 8'd25, 1'b1, 8'd5, 1'b0, lat);
        for (int i = 0; i < LC + 1; i++) begin
            @(negedge clk_in);
            chk("stale_no_rsp", 32'(rsp_valid_out), 0);
        end
        drain();
        stale_mode = 1'b0;

        // Reset in WAIT aborts the job silently.
        eng_lat = 20;
        issue(2, 8'd99, 8'd33, 1'b0, 8'd0, 1'b0, lat);
        repeat (LC + 1) @(negedge clk_in);
        chk("pre_rst_busy", 32'(busy_out), 1);
        rst_n_in = 1'b0;
        @(negedge clk_in);
        chk("mid_rst_busy", 32'(busy_out), 0);
        chk("mid_rst_eng_go", 32'(eng_go_out), 0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid_out), 0);
        rst_n_in = 1'b1;
        repeat (30) @(negedge clk_in);
        eng_lat = 3;
        issue(0, 8'd21, 8'd14, 1'b1, 8'd7, 1'b0, lat);
        chk("post_rst_gnt_lat", 32'(lat), 1);
        drain();

`ifdef GCD_SCHED_TIMEOUT_EN
        eng_off = 1'b1;
        issue(1, 8'd10, 8'd4, 1'b1, 8'd0, 1'b1, lat);
        wait_rsp(n);
        chk("timeout_lat", 32'(n), 32'(LC + TC));
        drain();
        chk("timeout_idle", 32'(busy_out), 0);
        eng_off = 1'b0;
`endif

        repeat (3) @(negedge clk_in);
        chk("gq_empty", 32'(gq.size()), 0);
        chk("rq_empty", 32'(rq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
